instr_encoder_loader: RTL and testbench

- Producer-side counterpart to the pipeline's decode stage: accepts instruction fields (class, ALU op, S, immediate select, load/store, cond, registers, immediates) on a valid/ready handshake.
- Assembles the 32-bit instruction word in the processor's subset format, buffers it in a small FIFO, and writes it sequentially into instruction memory.
- Used by boot/test infrastructure to load programs that the fetch/decode path later executes.

---
 rtl/instr_encoder_loader_if.sv | 38 +++
 rtl/instr_encoder_loader.sv | 98 +++++++++
 tb/tb_instr_encoder_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle input handshake, instruction-memory write port and loader status.
// The producer/memory side uses master, the encoder uses slave.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        kind;
    logic [1:0]        alu_op;
    logic              s_bit;
    logic              imm_sel;
    logic              load;
    logic [3:0]        cond;
    logic [3:0]        rn;
    logic [3:0]        rd;
    logic [3:0]        rm;
    logic [11:0]       imm12;
    logic [23:0]       imm24;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [15:0]       words_written;
    logic              busy;
    logic              err;

    modport master (
        output in_valid, kind, alu_op, s_bit, imm_sel, load, cond, rn, rd, rm,
               imm12, imm24, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata, words_written, busy, err
    );

    modport slave (
        input  in_valid, kind, alu_op, s_bit, imm_sel, load, cond, rn, rd, rm,
               imm12, imm24, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata, words_written, busy, err
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes instruction field bundles into 32-bit words, queues them in a small
// FIFO and streams them into instruction memory at consecutive word addresses.
module instr_encoder_loader #(
    parameter int              ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              DEPTH     = 4
) (
    input logic                    clk,
    input logic                    reset,
    input logic                    restart,
    instr_encoder_loader_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] KIND_DP  = 2'b00;
    localparam logic [1:0] KIND_MEM = 2'b01;
    localparam logic [1:0] KIND_BR  = 2'b10;

    logic [31:0]       mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       words_written;
    logic              err;

    logic        empty;
    logic        full;
    logic        accept;
    logic        push;
    logic        pop;
    logic [31:0] word;
    logic [3:0]  cmd;
    logic [11:0] src2;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign accept = bus.in_valid && !full && !restart;
    assign push   = accept && (bus.kind != 2'b11);
    assign pop    = !empty && bus.imem_ready && !restart;

    always_comb begin
        cmd  = 4'b0100;
        src2 = bus.imm_sel ? bus.imm12 : {8'b0, bus.rm};
        word = '0;
        case (bus.alu_op)
            2'b00:   cmd = 4'b0100;
            2'b01:   cmd = 4'b0010;
            2'b10:   cmd = 4'b0000;
            default: cmd = 4'b1100;
        endcase
        case (bus.kind)
            KIND_DP:  word = {bus.cond, 2'b00, bus.imm_sel, cmd, bus.s_bit, bus.rn, bus.rd, src2};
            // P=1 U=1 B=0 W=0; the I bit is inverted for memory transfers
            KIND_MEM: word = {bus.cond, 2'b01, ~bus.imm_sel, 4'b1100, bus.load, bus.rn, bus.rd, src2};
            KIND_BR:  word = {bus.cond, 4'b1010, bus.imm24};
            default:  word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            addr          <= BASE_ADDR;
            words_written <= '0;
            err           <= 1'b0;
        end else if (restart) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            addr          <= BASE_ADDR;
            words_written <= '0;
            err           <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (accept && bus.kind == 2'b11)
                err <= 1'b1;
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                addr          <= addr + ADDR_W'(4);
                words_written <= words_written + 16'd1;
            end
        end
    end

    assign bus.in_ready      = !full;
    assign bus.imem_we       = !empty;
    assign bus.imem_addr     = addr;
    assign bus.imem_wdata    = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];
    assign bus.words_written = words_written;
    assign bus.busy          = !empty;
    assign bus.err           = err;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encodings, backpressure, full FIFO,
// illegal kind, restart and asynchronous reset mid-drain.
module tb_instr_encoder_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic restart = 1'b0;
    int   checks = 0;
    int   errors = 0;

    instr_encoder_loader_if #(.ADDR_W(32)) bus ();

    instr_encoder_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] k, input logic [1:0] op, input logic s,
                         input logic isel, input logic ld, input logic [3:0] c,
                         input logic [3:0] n, input logic [3:0] d, input logic [3:0] m,
                         input logic [11:0] i12, input logic [23:0] i24);
        bus.kind    = k;
        bus.alu_op  = op;
        bus.s_bit   = s;
        bus.imm_sel = isel;
        bus.load    = ld;
        bus.cond    = c;
        bus.rn      = n;
        bus.rd      = d;
        bus.rm      = m;
        bus.imm12   = i12;
        bus.imm24   = i24;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.imem_ready = 1'b0;
        drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h0, 24'h0);
        step();
        step();
        chk("rst_we", {31'b0, bus.imem_we}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_wdata", bus.imem_wdata, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_ww", {16'b0, bus.words_written}, 32'd0);
        chk("rst_err", {31'b0, bus.err}, 32'd0);
        #3 reset = 1'b0;
        step();

        // ADD R1,R2,#5 visible one cycle after acceptance
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 4'hE, 4'd2, 4'd1, 4'd0, 12'h005, 24'h0);
        bus.in_valid = 1'b1;
        chk("pre_accept_we", {31'b0, bus.imem_we}, 32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("add_we", {31'b0, bus.imem_we}, 32'd1);
        chk("add_wdata", bus.imem_wdata, 32'hE2821005);
        chk("add_addr", bus.imem_addr, 32'h0);
        bus.imem_ready = 1'b1;
        step();
        chk("add_ww", {16'b0, bus.words_written}, 32'd1);
        chk("add_addr_after", bus.imem_addr, 32'h4);
        do_restart();
        chk("restart1_addr", bus.imem_addr, 32'h0);
        chk("restart1_ww", {16'b0, bus.words_written}, 32'd0);

        // SUBS R3,R4,R5 then ORR R6,R7,R8 back to back
        drive(2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 4'hE, 4'd4, 4'd3, 4'd5, 12'h0, 24'h0);
        bus.in_valid = 1'b1;
        step();
        chk("subs_wdata", bus.imem_wdata, 32'hE0543005);
        chk("subs_addr", bus.imem_addr, 32'h0);
        drive(2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 4'h0, 4'd7, 4'd6, 4'd8, 12'h0, 24'h0);
        step();
        bus.in_valid = 1'b0;
        chk("orr_wdata", bus.imem_wdata, 32'h01876008);
        chk("orr_addr", bus.imem_addr, 32'h4);
        step();
        chk("b2b_ww", {16'b0, bus.words_written}, 32'd2);
        chk("b2b_we", {31'b0, bus.imem_we}, 32'd0);

        // LDR / STR / B queued under backpressure, then drained
        bus.imem_ready = 1'b0;
        bus.in_valid = 1'b1;
        drive(2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 4'hE, 4'd1, 4'd0, 4'd0, 12'h008, 24'h0);
        step();
        drive(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 4'hE, 4'd3, 4'd2, 4'd0, 12'h004, 24'h0);
        step();
        drive(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 4'hE, 4'd9, 4'd9, 4'd9, 12'hFFF, 24'hFFFFFE);
        step();
        bus.in_valid = 1'b0;
        chk("ldr_wdata", bus.imem_wdata, 32'hE5910008);
        chk("ldr_addr", bus.imem_addr, 32'h8);
        bus.imem_ready = 1'b1;
        step();
        chk("str_wdata", bus.imem_wdata, 32'hE5832004);
        chk("str_addr", bus.imem_addr, 32'hC);
        step();
        chk("b_wdata", bus.imem_wdata, 32'hEAFFFFFE);
        chk("b_addr", bus.imem_addr, 32'h10);
        step();
        chk("mem_ww", {16'b0, bus.words_written}, 32'd5);

        // fill FIFO with backpressure, fifth bundle must wait
        do_restart();
        bus.imem_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 4'hE, 4'd2, 4'(i), 4'd0, 12'(i), 24'h0);
            chk($sformatf("fill_ready_%0d", i), {31'b0, bus.in_ready}, 32'd1);
            step();
        end
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 4'hE, 4'd2, 4'd4, 4'd0, 12'h004, 24'h0);
        chk("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("full_wdata", bus.imem_wdata, 32'hE2820000);
        step();
        step();
        chk("stall_wdata", bus.imem_wdata, 32'hE2820000);
        chk("stall_addr", bus.imem_addr, 32'h0);
        chk("stall_we", {31'b0, bus.imem_we}, 32'd1);
        chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
        bus.imem_ready = 1'b1;
        step();
        chk("drain1_wdata", bus.imem_wdata, 32'hE2821001);
        chk("drain1_addr", bus.imem_addr, 32'h4);
        chk("drain1_in_ready", {31'b0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        for (int i = 2; i < 5; i++) begin
            chk($sformatf("drain_wdata_%0d", i), bus.imem_wdata,
                32'hE2820000 | (32'(i) << 12) | 32'(i));
            chk($sformatf("drain_addr_%0d", i), bus.imem_addr, 32'(4 * i));
            step();
        end
        chk("fill_ww", {16'b0, bus.words_written}, 32'd5);
        chk("fill_busy", {31'b0, bus.busy}, 32'd0);

        // illegal kind: sticky err, nothing written
        drive(2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 4'hE, 4'd1, 4'd1, 4'd1, 12'h0, 24'h0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("ill_err", {31'b0, bus.err}, 32'd1);
        chk("ill_we", {31'b0, bus.imem_we}, 32'd0);
        chk("ill_addr", bus.imem_addr, 32'h14);
        step();
        chk("ill_err_sticky", {31'b0, bus.err}, 32'd1);
        chk("ill_ww", {16'b0, bus.words_written}, 32'd5);
        // restart drops a concurrent bundle
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 4'hE, 4'd2, 4'd1, 4'd0, 12'h005, 24'h0);
        bus.in_valid = 1'b1;
        do_restart();
        bus.in_valid = 1'b0;
        chk("rs_err", {31'b0, bus.err}, 32'd0);
        chk("rs_addr", bus.imem_addr, 32'h0);
        chk("rs_busy", {31'b0, bus.busy}, 32'd0);
        chk("rs_ww", {16'b0, bus.words_written}, 32'd0);

        // async reset with three words buffered
        bus.imem_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 4'hE, 4'(i), 4'(i), 4'(i), 12'h0, 24'h0);
            step();
        end
        bus.in_valid = 1'b0;
        bus.imem_ready = 1'b1;
        step();
        chk("pre_rst_ww", {16'b0, bus.words_written}, 32'd1);
        chk("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_we", {31'b0, bus.imem_we}, 32'd0);
        chk("async_ww", {16'b0, bus.words_written}, 32'd0);
        chk("async_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 4'hE, 4'd2, 4'd1, 4'd0, 12'h005, 24'h0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("post_rst_wdata", bus.imem_wdata, 32'hE2821005);
        chk("post_rst_addr", bus.imem_addr, 32'h0);
        step();
        chk("post_rst_ww", {16'b0, bus.words_written}, 32'd1);
        chk("post_rst_addr2", bus.imem_addr, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
